vi_main_memory: RTL and testbench

- Synthesizable main-memory responder: the memory side of the vi_core memory interface.
- Accepts 128-bit line reads and 32-bit word or byte writes issued by the core's mem_* request ports.
- Returns each read line after a programmable latency with a one-cycle ready pulse and echoed address.
- Replaces the behavioural bench memory so full-system simulation and FPGA builds use the same interface timing.

---
 rtl/vi_main_memory.sv | 101 ++++++++++
 tb/tb_vi_main_memory.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vi_main_memory.sv
// vi_main_memory: line-read / word-byte-write main memory with programmable read latency.
// Define MEM_OOR_ERR_EN to add mem_err_o and reject addresses above the array.
module vi_main_memory #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int IDX_W   = 12,
  parameter int LATENCY = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              mem_read_i,
  input  logic [ADDR_W-1:0] mem_read_addr_i,
  input  logic              mem_write_enable_i,
  input  logic              mem_write_byte_i,
  input  logic [ADDR_W-1:0] mem_write_addr_i,
  input  logic [31:0]       mem_write_data_i,
  output logic              mem_data_ready_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o
`ifdef MEM_OOR_ERR_EN
  ,
  output logic              mem_err_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] req_addr, rd_addr;
  logic [IDX_W-1:0] ridx, widx;
  logic [15:0] be;
  logic [LINE_W-1:0] wd, rd_line, fwd_line;
  logic [LINE_W-1:0] mem [2**IDX_W];
  logic w_oor, r_oor, wr_en;

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (mem_read_i) begin
        state_nx = (LATENCY == 1) ? RESP : WAIT;
        cnt_nx = CNT_INIT;
      end
      WAIT: if (cnt == '0) state_nx = RESP; else cnt_nx = cnt - 8'd1;
      RESP: state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_data_ready_o = (state == RESP);
  // With LATENCY=1 the response is captured on the accepting edge, before req_addr is loaded.
  assign rd_addr = (state == IDLE) ? mem_read_addr_i : req_addr;
  assign ridx = rd_addr[IDX_W+3:4];
  assign widx = mem_write_addr_i[IDX_W+3:4];
  assign be = mem_write_byte_i ? 16'(1) << mem_write_addr_i[3:0] : 16'hF << {mem_write_addr_i[3:2], 2'b00};
  assign wd = mem_write_byte_i ? {16{mem_write_data_i[7:0]}} : {4{mem_write_data_i}};
  assign wr_en = mem_write_enable_i & ~w_oor;
  assign rd_line = mem[ridx];

  always_comb begin
    fwd_line = rd_line;
    for (int b = 0; b < 16; b++)
      if (wr_en && widx == ridx && be[b]) fwd_line[b*8 +: 8] = wd[b*8 +: 8];
  end

  always_ff @(posedge clk_i)
    if (wr_en)
      for (int b = 0; b < 16; b++)
        if (be[b]) mem[widx][b*8 +: 8] <= wd[b*8 +: 8];

  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      state <= IDLE;
      cnt <= '0;
      req_addr <= '0;
      mem_data_o <= '0;
      mem_addr_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && mem_read_i) req_addr <= mem_read_addr_i;
      if (state_nx == RESP) begin
        mem_data_o <= r_oor ? '0 : fwd_line;
        mem_addr_o <= rd_addr;
      end
    end

`ifdef MEM_OOR_ERR_EN
  assign w_oor = |mem_write_addr_i[ADDR_W-1:IDX_W+4];
  assign r_oor = |rd_addr[ADDR_W-1:IDX_W+4];
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) mem_err_o <= 1'b0;
    else mem_err_o <= (state_nx == RESP && r_oor) | (mem_write_enable_i && w_oor);
`else
  logic unused_hi;
  assign unused_hi = ^mem_write_addr_i[ADDR_W-1:IDX_W+4];
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif
endmodule

// File: tb/tb_vi_main_memory.sv
// tb_vi_main_memory: directed self-checking bench for vi_main_memory (LATENCY=5).
module tb_vi_main_memory;
  logic clk = 0, rsn = 0, rd_req = 0, we = 0, wbyte = 0;
  logic [19:0] raddr = '0, waddr = '0, addr_o;
  logic [31:0] wdata = '0;
  logic ready, err_w;
  logic [127:0] data_o;
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  vi_main_memory dut (
    .clk_i(clk), .rsn_i(rsn), .mem_read_i(rd_req), .mem_read_addr_i(raddr),
    .mem_write_enable_i(we), .mem_write_byte_i(wbyte), .mem_write_addr_i(waddr),
    .mem_write_data_i(wdata), .mem_data_ready_o(ready), .mem_data_o(data_o),
    .mem_addr_o(addr_o)
`ifdef MEM_OOR_ERR_EN
    , .mem_err_o(err_w)
`endif
  );
`ifndef MEM_OOR_ERR_EN
  assign err_w = 1'b0;
`endif

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic b);
    @(negedge clk);
    we = 1; wbyte = b; waddr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input logic [19:0] a, output int lat, output logic [127:0] d,
                    output logic [19:0] ao, output logic e);
    @(negedge clk);
    rd_req = 1; raddr = a; lat = 0;
    do begin @(negedge clk); lat++; end while (!ready && lat < 300);
    rd_req = 0; d = data_o; ao = addr_o; e = err_w;
    @(negedge clk);
    chk("gap_ready_low", 128'(ready), 128'(0));
    chk("gap_data_hold", data_o, d);
  endtask

  int lat, t, np;
  int p[3];
  logic [127:0] d;
  logic [19:0] ao;
  logic e;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_data", data_o, 128'(0));
    chk("rst_addr", 128'(addr_o), 128'(0));
    rsn = 1;

    wr(20'h01000, 32'h11111111, 0);
    wr(20'h01004, 32'hDEADBEEF, 0);
    wr(20'h01008, 32'h22222222, 0);
    wr(20'h0100C, 32'h33333333, 0);
    rd(20'h01000, lat, d, ao, e);
    chk("word_lat", 128'(lat), 128'(5));
    chk("word_data", d, 128'h33333333_22222222_DEADBEEF_11111111);
    chk("word_addr", 128'(ao), 128'h01000);

    for (int i = 0; i < 4; i++) wr(20'h01000 + 20'(4 * i), 32'hFFFFFFFF, 0);
    wr(20'h0100F, 32'hFFFFFFA5, 1);
    wr(20'h01005, 32'h0000005A, 1);
    rd(20'h01004, lat, d, ao, e);
    chk("byte_data", d, 128'hA5FFFFFF_FFFFFFFF_FFFF5AFF_FFFFFFFF);
    chk("byte_addr", 128'(ao), 128'h01004);

    @(negedge clk);
    rd_req = 1; raddr = 20'h01000; t = 0; np = 0; p = '{0, 0, 0};
    while (np < 3 && t < 100) begin
      @(negedge clk); t++;
      if (ready) begin p[np] = t; np++; end
    end
    rd_req = 0;
    chk("cont_first", 128'(p[0]), 128'(5));
    chk("cont_space1", 128'(p[1] - p[0]), 128'(7));
    chk("cont_space2", 128'(p[2] - p[1]), 128'(7));
    repeat (3) @(negedge clk);

    wr(20'h02000, 32'hA0000000, 0);
    wr(20'h02004, 32'hA1000000, 0);
    wr(20'h02008, 32'hA2000000, 0);
    wr(20'h0200C, 32'hA3000000, 0);
    @(negedge clk);
    rd_req = 1; raddr = 20'h02000;
    repeat (4) @(negedge clk);
    we = 1; wbyte = 0; waddr = 20'h02008; wdata = 32'hCAFEF00D;
    @(negedge clk);
    we = 0;
    chk("fwd_ready", 128'(ready), 128'(1));
    chk("fwd_data", data_o, 128'hA3000000_CAFEF00D_A1000000_A0000000);
    rd_req = 0;
    repeat (2) @(negedge clk);
    rd(20'h02000, lat, d, ao, e);
    chk("fwd_commit", d, 128'hA3000000_CAFEF00D_A1000000_A0000000);

    @(negedge clk);
    rd_req = 1; raddr = 20'h01000;
    repeat (2) @(negedge clk);
    rd_req = 0; rsn = 0;
    #1;
    chk("arst_ready", 128'(ready), 128'(0));
    chk("arst_data", data_o, 128'(0));
    chk("arst_addr", 128'(addr_o), 128'(0));
    @(negedge clk);
    rsn = 1; np = 0;
    repeat (12) begin @(negedge clk); if (ready) np++; end
    chk("arst_no_resp", 128'(np), 128'(0));
    chk("arst_data_after", data_o, 128'(0));
    rd(20'h01000, lat, d, ao, e);
    chk("arst_idle_lat", 128'(lat), 128'(5));

    for (int i = 0; i < 4; i++) wr(20'h00000 + 20'(4 * i), 32'(i + 1), 0);
    rd(20'h10000, lat, d, ao, e);
    chk("oor_addr", 128'(ao), 128'h10000);
`ifdef MEM_OOR_ERR_EN
    chk("oor_data", d, 128'(0));
    chk("oor_err", 128'(e), 128'(1));
`else
    chk("alias_data", d, 128'h00000004_00000003_00000002_00000001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
